debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent button channels (range 1..32).
REQ-002 The block SHALL have parameter CLK_HZ, default 50_000_000, giving the dbClk frequency in Hz.
REQ-003 The block SHALL have parameter TICK_HZ, default 1000, giving the sample-tick rate in Hz; DIV = CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-004 The block SHALL have parameter STABLE_TICKS, default 4, giving the number of consecutive ticks (at least 1) needed to accept a level change.
REQ-005 The block SHALL have parameter REPEAT_DELAY, default 500, giving the number of ticks held before the first repeat.
REQ-006 The block SHALL have parameter REPEAT_PERIOD, default 100, giving the number of ticks between subsequent repeats.
REQ-007 The block SHALL have port dbClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port dbRst, input, 1 bit: reset, which is synchronous and active-low.
REQ-009 The block SHALL have port dbButtonIn, input, CHANNELS bits: raw asynchronous button levels, 1 = pressed.
REQ-010 The block SHALL have port dbLevel, output, CHANNELS bits: debounced level per channel.
REQ-011 The block SHALL have port dbPress, output, CHANNELS bits: a one-cycle pulse on an accepted press.
REQ-012 The block SHALL have port dbRelease, output, CHANNELS bits: a one-cycle pulse on an accepted release.
REQ-013 The block SHALL have port dbRepeat, output, CHANNELS bits: a one-cycle auto-repeat pulse while a channel is held.

Function
REQ-014 The block SHALL pass each dbButtonIn bit through a 2-flop synchroniser before any other use.
REQ-015 The block SHALL implement one shared prescaler counting 0..DIV-1, with tick high for exactly one dbClk cycle when count = DIV-1, then wrapping to 0.
REQ-016 Each channel SHALL implement an FSM with states IDLE, PRESS_PEND, HELD and REL_PEND, and SHALL evaluate it only on tick cycles.
REQ-017 In IDLE, a synchronised input of 1 on a tick SHALL move the channel to PRESS_PEND with its stable counter set to 1.
REQ-018 In PRESS_PEND, a synchronised 0 on a tick SHALL return the channel to IDLE with the counter cleared; a synchronised 1 SHALL increment the counter.
REQ-019 When the counter reaches STABLE_TICKS, the channel SHALL move to HELD, and dbLevel SHALL become 1 and dbPress SHALL pulse on that same edge.
REQ-020 HELD and REL_PEND SHALL mirror IDLE and PRESS_PEND with the polarity inverted; acceptance SHALL return the channel to IDLE, clear dbLevel and pulse dbRelease.
REQ-021 If STABLE_TICKS = 1, a change seen on a single tick SHALL be accepted on that tick.
REQ-022 Accepted-change latency SHALL be 2 dbClk cycles of synchronisation plus between STABLE_TICKS-1 and STABLE_TICKS tick periods, with no more than one cycle of extra skew.
REQ-023 The stable counter SHALL be $clog2(STABLE_TICKS+1) bits wide and SHALL saturate; it SHALL never wrap.
REQ-024 dbPress, dbRelease and dbRepeat SHALL each be high for exactly one dbClk cycle per event, and never high in two consecutive cycles.
REQ-025 Channels SHALL be fully independent; simultaneous events on any number of channels SHALL all be reported in the same cycle.
REQ-026 Bounces shorter than STABLE_TICKS ticks SHALL produce no output change and no pulse.

Reset
REQ-027 When dbRst = 0 on a rising dbClk edge, all outputs SHALL be 0, all FSMs SHALL be in IDLE, and all counters, the prescaler and the synchroniser flops SHALL be 0.
REQ-028 Reset asserted mid-operation, including during a pending state, SHALL discard the pending event; no pulse SHALL be emitted for it.
REQ-029 A button held through reset SHALL be treated as a new press: dbPress SHALL pulse once after the normal acceptance time following reset release.

Configuration
REQ-030 When DEBOUNCE_BANK_REPEAT_EN is defined, each channel in HELD SHALL count ticks, pulse dbRepeat at REPEAT_DELAY ticks after acceptance, and pulse it again every REPEAT_PERIOD ticks after that.
REQ-031 With DEBOUNCE_BANK_REPEAT_EN defined, the repeat counter SHALL clear on leaving HELD, and entering REL_PEND SHALL suspend repeats.
REQ-032 When DEBOUNCE_BANK_REPEAT_EN is not defined, the repeat counters SHALL be absent and dbRepeat SHALL be tied to all-zeros, with the port list unchanged.

Structure
REQ-033 Shared package debounce_pkg SHALL hold the channel state typedef (IDLE, PRESS_PEND, HELD, REL_PEND) and the constant 2-bit state encodings.
REQ-034 Sub-module debounce_channel SHALL contain one channel's synchroniser, FSM, counters and pulse outputs, and SHALL be generated CHANNELS times; the prescaler SHALL stay in debounce_bank.

Verification (CLK_HZ=1000, TICK_HZ=100, so DIV=10; STABLE_TICKS=4; REPEAT_DELAY=8; REPEAT_PERIOD=3; CHANNELS=4)
REQ-035 Clean press: ch0 driven 0->1 and held -> dbLevel[0] rises 30-40 cycles later plus sync delay, with a single one-cycle dbPress[0] and no other channel toggling.
REQ-036 Bounce rejection: ch1 toggled high for 25 cycles, low for 5 cycles, repeated 4 times -> dbLevel[1] stays 0 and no pulses occur.
REQ-037 Simultaneous events: ch0 and ch3 pressed on the same cycle -> dbPress equals 4'b1001 for one cycle.
REQ-038 Release: ch2 held and then released -> one dbRelease[2] pulse, and dbLevel[2] returns to 0 after 4 ticks.
REQ-039 Auto-repeat (macro defined): ch0 held for 20 ticks -> dbRepeat[0] pulses at ticks 8, 11, 14, 17 and 20 after acceptance; with the macro undefined, dbRepeat stays 0.
REQ-040 Reset mid-pend: ch0 pressed, dbRst driven 0 for 1 cycle after 2 ticks, input still held -> all outputs 0 during reset, then one dbPress[0] pulse 4 ticks after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: per-channel state type and its fixed 2-bit encodings.
package debounce_pkg;

   localparam logic [1:0] ST_IDLE       = 2'b00;
   localparam logic [1:0] ST_PRESS_PEND = 2'b01;
   localparam logic [1:0] ST_HELD       = 2'b11;
   localparam logic [1:0] ST_REL_PEND   = 2'b10;

   typedef enum logic [1:0] {
      IDLE       = ST_IDLE,
      PRESS_PEND = ST_PRESS_PEND,
      HELD       = ST_HELD,
      REL_PEND   = ST_REL_PEND
   } chanState_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-driven debounce FSM and event pulses.
// Auto-repeat is built only when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS  = 4,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic dbClk,
   input  logic dbRst,
   input  logic tick,
   input  logic buttonIn,
   output logic level,
   output logic pressPulse,
   output logic releasePulse,
   output logic repeatPulse
);

   localparam int CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS);

   if (STABLE_TICKS < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : gBadConfig
      $error("debounce_channel: invalid STABLE_TICKS / REPEAT_DELAY / REPEAT_PERIOD");
   end

   logic syncA;
   logic syncB;
   chanState_t state;
   logic [CNT_W-1:0] stableCnt;
   logic [CNT_W-1:0] nextCnt;

   always_ff @(posedge dbClk) begin
      if (!dbRst) begin
         syncA <= 1'b0;
         syncB <= 1'b0;
      end else begin
         syncA <= buttonIn;
         syncB <= syncA;
      end
   end

   // Saturating agreement count; acceptance happens on the tick that makes it reach CNT_MAX.
   assign nextCnt = (stableCnt == CNT_MAX) ? CNT_MAX : stableCnt + 1'b1;

   always_ff @(posedge dbClk) begin
      if (!dbRst) begin
         state        <= IDLE;
         stableCnt    <= '0;
         level        <= 1'b0;
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
      end else begin
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
         if (tick) begin
            unique case (state)
               IDLE, PRESS_PEND: begin
                  if (!syncB) begin
                     state     <= IDLE;
                     stableCnt <= '0;
                  end else if (nextCnt == CNT_MAX) begin
                     state      <= HELD;
                     stableCnt  <= '0;
                     level      <= 1'b1;
                     pressPulse <= 1'b1;
                  end else begin
                     state     <= PRESS_PEND;
                     stableCnt <= nextCnt;
                  end
               end
               HELD, REL_PEND: begin
                  if (syncB) begin
                     state     <= HELD;
                     stableCnt <= '0;
                  end else if (nextCnt == CNT_MAX) begin
                     state        <= IDLE;
                     stableCnt    <= '0;
                     level        <= 1'b0;
                     releasePulse <= 1'b1;
                  end else begin
                     state     <= REL_PEND;
                     stableCnt <= nextCnt;
                  end
               end
            endcase
         end
      end
   end

`ifdef DEBOUNCE_BANK_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [REP_W-1:0] repCnt;
   logic [REP_W-1:0] repNext;

   assign repNext = repCnt + 1'b1;

   // Reloading to DELAY-PERIOD after each pulse makes later repeats land every PERIOD ticks.
   always_ff @(posedge dbClk) begin
      if (!dbRst) begin
         repCnt      <= '0;
         repeatPulse <= 1'b0;
      end else begin
         repeatPulse <= 1'b0;
         if (state != HELD) begin
            repCnt <= '0;
         end else if (tick && syncB) begin
            if (repNext == REP_FIRST) begin
               repeatPulse <= 1'b1;
               repCnt      <= REP_RELOAD;
            end else begin
               repCnt <= repNext;
            end
         end
      end
   end
`else
   assign repeatPulse = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced buttons sharing one sample-tick prescaler.
// Define DEBOUNCE_BANK_REPEAT_EN to enable auto-repeat pulses on dbRepeat.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int CLK_HZ        = 50_000_000,
   parameter int TICK_HZ       = 1000,
   parameter int STABLE_TICKS  = 4,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic                dbClk,
   input  logic                dbRst,
   input  logic [CHANNELS-1:0] dbButtonIn,
   output logic [CHANNELS-1:0] dbLevel,
   output logic [CHANNELS-1:0] dbPress,
   output logic [CHANNELS-1:0] dbRelease,
   output logic [CHANNELS-1:0] dbRepeat
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   if (CHANNELS < 1 || CHANNELS > 32 || DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : gBadConfig
      $error("debounce_bank: invalid CHANNELS / CLK_HZ / TICK_HZ");
   end

   logic [PRE_W-1:0] preCnt;
   logic             tick;

   assign tick = (preCnt == PRE_LAST);

   always_ff @(posedge dbClk) begin
      if (!dbRst) begin
         preCnt <= '0;
      end else if (tick) begin
         preCnt <= '0;
      end else begin
         preCnt <= preCnt + 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : gChan
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) uChannel (
         .dbClk       (dbClk),
         .dbRst       (dbRst),
         .tick        (tick),
         .buttonIn    (dbButtonIn[i]),
         .level       (dbLevel[i]),
         .pressPulse  (dbPress[i]),
         .releasePulse(dbRelease[i]),
         .repeatPulse (dbRepeat[i])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected events, a negedge monitor checks them.
module tb_debounce_bank;

   localparam int CH = 4;

   logic          dbClk = 1'b0;
   logic          dbRst = 1'b0;
   logic [CH-1:0] dbButtonIn = '0;
   logic [CH-1:0] dbLevel;
   logic [CH-1:0] dbPress;
   logic [CH-1:0] dbRelease;
   logic [CH-1:0] dbRepeat;

   int checks   = 0;
   int errors   = 0;
   int clkCount = 0;
   int cyc      = 0;

   typedef struct {
      string         name;
      logic [CH-1:0] press;
      logic [CH-1:0] rel;
      logic [CH-1:0] rep;
      logic [CH-1:0] lvl;
      int            issue;
      int            minD;
      int            maxD;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon;
   int            monDelay;
   logic [CH-1:0] monPulses;
   logic [CH-1:0] prevPulse = '0;

   debounce_bank #(
      .CHANNELS     (CH),
      .CLK_HZ       (1000),
      .TICK_HZ      (100),
      .STABLE_TICKS (4),
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(3)
   ) dut (
      .dbClk     (dbClk),
      .dbRst     (dbRst),
      .dbButtonIn(dbButtonIn),
      .dbLevel   (dbLevel),
      .dbPress   (dbPress),
      .dbRelease (dbRelease),
      .dbRepeat  (dbRepeat)
   );

   always #5 dbClk = ~dbClk;

   // cyc mirrors the prescaler phase: channel ticks act on edges where cyc is a nonzero multiple of 10.
   always @(posedge dbClk) begin
      clkCount++;
      if (!dbRst) cyc = 0;
      else        cyc++;
   end

   always @(negedge dbClk) begin
      if (dbRst) begin
         if (sb.size() != 0 && clkCount > sb[0].issue + sb[0].maxD) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: no event within %0d cycles of issue", sb[0].name, sb[0].maxD);
            void'(sb.pop_front());
         end
         monPulses = dbPress | dbRelease | dbRepeat;
         if (monPulses != '0) begin
            checks++;
            if ((monPulses & prevPulse) != '0) begin
               errors++;
               $display("[TB] FAIL pulse_width: pulses %b also high last cycle (%b), required single cycle", monPulses, prevPulse);
            end
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_event: press=%b release=%b repeat=%b level=%b, required no event",
                        dbPress, dbRelease, dbRepeat, dbLevel);
            end else begin
               mon = sb.pop_front();
               checks++;
               if (dbPress !== mon.press || dbRelease !== mon.rel || dbRepeat !== mon.rep || dbLevel !== mon.lvl) begin
                  errors++;
                  $display("[TB] FAIL %s: got press=%b release=%b repeat=%b level=%b, required press=%b release=%b repeat=%b level=%b",
                           mon.name, dbPress, dbRelease, dbRepeat, dbLevel, mon.press, mon.rel, mon.rep, mon.lvl);
               end
               checks++;
               monDelay = clkCount - mon.issue;
               if (monDelay < mon.minD || monDelay > mon.maxD) begin
                  errors++;
                  $display("[TB] FAIL %s latency: got %0d cycles, required %0d..%0d", mon.name, monDelay, mon.minD, mon.maxD);
               end
            end
         end
         prevPulse = monPulses;
      end else begin
         prevPulse = '0;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge dbClk);
      #1;
   endtask

   task automatic alignTick();
      do begin
         @(posedge dbClk);
         #1;
      end while (cyc == 0 || (cyc % 10) != 0);
   endtask

   task automatic applyStimulus(input logic [CH-1:0] buttons);
      dbButtonIn = buttons;
   endtask

   task automatic expectEvent(input string n, input logic [CH-1:0] p, input logic [CH-1:0] r,
                              input logic [CH-1:0] rp, input logic [CH-1:0] l, input int minD, input int maxD);
      exp_t e;
      e = '{n, p, r, rp, l, clkCount, minD, maxD};
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string n, input logic [CH-1:0] lvl);
      checks++;
      if ({dbLevel, dbPress, dbRelease, dbRepeat} !== {lvl, {(3*CH){1'b0}}}) begin
         errors++;
         $display("[TB] FAIL %s: got level=%b press=%b release=%b repeat=%b, required level=%b and no pulses",
                  n, dbLevel, dbPress, dbRelease, dbRepeat, lvl);
      end
   endtask

   initial begin
      dbRst = 1'b0;
      applyStimulus('1);
      waitCycles(3);
      checkOutput("reset_state", '0);
      applyStimulus('0);
      dbRst = 1'b1;
      waitCycles(20);

      $display("[TB] clean press on ch0, held long enough for auto-repeat");
      applyStimulus(4'b0001);
      expectEvent("press_ch0", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 32, 43);
`ifdef DEBOUNCE_BANK_REPEAT_EN
      for (int k = 8; k <= 20; k += 3)
         expectEvent("repeat_ch0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 32 + 10*k, 43 + 10*k);
`endif
      waitCycles(250);
      applyStimulus(4'b0000);
      expectEvent("release_ch0", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 32, 43);
      waitCycles(60);

      $display("[TB] bounce on ch1: 25 high / 5 low, four times");
      alignTick();
      for (int r = 0; r < 4; r++) begin
         applyStimulus(4'b0010);
         waitCycles(25);
         applyStimulus(4'b0000);
         waitCycles(5);
      end
      waitCycles(60);
      checkOutput("bounce_level", '0);

      $display("[TB] simultaneous press and release on ch0 and ch3");
      applyStimulus(4'b1001);
      expectEvent("press_ch0_ch3", 4'b1001, 4'b0000, 4'b0000, 4'b1001, 32, 43);
      waitCycles(60);
      applyStimulus(4'b0000);
      expectEvent("release_ch0_ch3", 4'b0000, 4'b1001, 4'b0000, 4'b0000, 32, 43);
      waitCycles(60);

      $display("[TB] press and release on ch2");
      applyStimulus(4'b0100);
      expectEvent("press_ch2", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 32, 43);
      waitCycles(60);
      checkOutput("held_ch2", 4'b0100);
      applyStimulus(4'b0000);
      expectEvent("release_ch2", 4'b0000, 4'b0100, 4'b0000, 4'b0000, 32, 43);
      waitCycles(60);

      $display("[TB] reset during pending press on ch0");
      alignTick();
      applyStimulus(4'b0001);
      waitCycles(22);
      dbRst = 1'b0;
      waitCycles(1);
      checkOutput("reset_midpend", '0);
      dbRst = 1'b1;
      expectEvent("press_after_reset", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 40, 40);
      waitCycles(60);
      applyStimulus(4'b0000);
      expectEvent("release_after_reset", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 32, 43);
      waitCycles(60);

      waitCycles(20);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d events outstanding, required 0", sb.size());
      end
      checkOutput("final_idle", '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
